// File: rtl/clk_enable_gen.sv
// Multi-channel tick-enable and phase generator with a start/pause/timeout run controller.
// Each channel divides enabled RUN cycles by a divisor that can be reprogrammed at run time.
module clk_enable_gen #(
    parameter int NUM_CHANNELS = 2,
    parameter int DIV_WIDTH    = 8,
    parameter int CNT_WIDTH    = 16,
    parameter int RESET_DIV    = 2,
    localparam int CH_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    start,
    input  logic                    div_load,
    input  logic [CH_W-1:0]         div_chan,
    input  logic [DIV_WIDTH-1:0]    div_value,
    input  logic [CNT_WIDTH-1:0]    timeout_value,
    output logic [NUM_CHANNELS-1:0] chan_tick,
    output logic [NUM_CHANNELS-1:0] chan_phase,
    output logic                    running,
    output logic                    done,
    output logic [CNT_WIDTH-1:0]    cycle_count
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CH_W:0] NUM_CH_EXT = NUM_CHANNELS[CH_W:0];

    state_t                 state;
    logic [CNT_WIDTH-1:0]   timeout_lat;
    logic [DIV_WIDTH-1:0]   cnt      [NUM_CHANNELS];
    logic [DIV_WIDTH-1:0]   act_div  [NUM_CHANNELS];
    logic [DIV_WIDTH-1:0]   shd_div  [NUM_CHANNELS];
    logic [DIV_WIDTH-1:0]   shd_next [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] wrap;
    logic                   load_ok;
    logic                   start_run;
    logic                   last_cycle;

    assign load_ok    = div_load && ({1'b0, div_chan} < NUM_CH_EXT);
    assign start_run  = start && (state != RUN);
    assign last_cycle = (state == RUN) && enable && (timeout_lat != '0) &&
                        (cycle_count == timeout_lat - CNT_WIDTH'(1));

    // A load landing on a wrap cycle is forwarded so the very next period already uses it.
    always_comb begin
        wrap = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            shd_next[i] = (load_ok && (div_chan == CH_W'(i))) ? div_value : shd_div[i];
            if (act_div[i] == '0)
                wrap[i] = (cnt[i] == '0);
            else
                wrap[i] = (cnt[i] == act_div[i] - DIV_WIDTH'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            timeout_lat <= '0;
            cycle_count <= '0;
            chan_tick   <= '0;
            chan_phase  <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                cnt[i]     <= '0;
                act_div[i] <= DIV_WIDTH'(RESET_DIV);
                shd_div[i] <= DIV_WIDTH'(RESET_DIV);
            end
        end else begin
            chan_tick <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++)
                shd_div[i] <= shd_next[i];
            case (state)
                IDLE, DONE: begin
                    if (start_run) begin
                        state       <= RUN;
                        timeout_lat <= timeout_value;
                        cycle_count <= '0;
                        chan_phase  <= '0;
                        for (int i = 0; i < NUM_CHANNELS; i++) begin
                            cnt[i]     <= '0;
                            act_div[i] <= shd_next[i];
                        end
                    end
                end
                RUN: begin
                    if (enable) begin
                        if (cycle_count != '1)
                            cycle_count <= cycle_count + CNT_WIDTH'(1);
                        if (last_cycle)
                            state <= DONE;
                        // Ticks are suppressed on the edge that leaves RUN.
                        for (int i = 0; i < NUM_CHANNELS; i++) begin
                            if (wrap[i]) begin
                                cnt[i]        <= '0;
                                chan_tick[i]  <= !last_cycle;
                                chan_phase[i] <= ~chan_phase[i];
                                act_div[i]    <= shd_next[i];
                            end else begin
                                cnt[i] <= cnt[i] + DIV_WIDTH'(1);
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign running = (state == RUN);
    assign done    = (state == DONE);

endmodule
